// File: rtl/deskew_sequencer_if.sv
// Handshake bundle between the LTSSM, the lane deskew controller and the
// deskew sequencer.
interface deskew_sequencer_if #(
   parameter int lane_count = 32,
   parameter int MAX_RETRY  = 3
);
   localparam int RW = $clog2(MAX_RETRY + 1);

   logic                  deskew_req;
   logic                  Deskew_error;
   logic                  valid_deskew;
   logic [lane_count-1:0] valid_data;
   logic                  EN_LTSSM;
   logic                  Soft_RST_blocks;
   logic                  deskew_locked;
   logic                  deskew_fail;
   logic                  rx_data_gate;
   logic [RW-1:0]         retry_cnt;

   modport master (
      input  deskew_req,
      input  Deskew_error,
      input  valid_deskew,
      input  valid_data,
      output EN_LTSSM,
      output Soft_RST_blocks,
      output deskew_locked,
      output deskew_fail,
      output rx_data_gate,
      output retry_cnt
   );

   modport slave (
      output deskew_req,
      output Deskew_error,
      output valid_deskew,
      output valid_data,
      input  EN_LTSSM,
      input  Soft_RST_blocks,
      input  deskew_locked,
      input  deskew_fail,
      input  rx_data_gate,
      input  retry_cnt
   );
endinterface

// File: rtl/deskew_sequencer.sv
// Lane deskew sequencer: flush, arm, wait for lock with bounded retries,
// and gate RX data until lanes are aligned.
module deskew_sequencer #(
   parameter int lane_count   = 32,
   parameter int FLUSH_CYCLES = 4,
   parameter int SDS_TIMEOUT  = 1024,
   parameter int MAX_RETRY    = 3
) (
   input  logic               RX_CLK,
   input  logic               rst,
   deskew_sequencer_if.master bus
);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int TW = $clog2(SDS_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, FLUSH, ARM, BACKOFF, LOCKED, FAIL
   } state_t;

   state_t        state;
   state_t        next;
   logic [3:0]    flush_cnt;
   logic [TW-1:0] timer;
   logic [RW-1:0] retry;
   logic          aligned;

   assign aligned = bus.valid_deskew & (&bus.valid_data);

   always_comb begin
      next = state;
      unique case (state)
         IDLE:
            if (bus.deskew_req) next = FLUSH;
         FLUSH:
            if (flush_cnt == 4'(FLUSH_CYCLES - 1)) next = ARM;
         ARM:
            // first ARM cycle ignored: controller flags still settling
            if (timer != '0) begin
               if (bus.Deskew_error) next = BACKOFF;
               else if (aligned) next = LOCKED;
               else if (timer == TW'(SDS_TIMEOUT - 1)) next = BACKOFF;
            end
         BACKOFF:
            next = (retry == RW'(MAX_RETRY)) ? FAIL : FLUSH;
         LOCKED:
            if (bus.Deskew_error) next = BACKOFF;
         FAIL:
            next = FAIL;
         default:
            next = IDLE;
      endcase
      if (!bus.deskew_req && state != IDLE) next = IDLE;
   end

   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         state               <= IDLE;
         flush_cnt           <= '0;
         timer               <= '0;
         retry               <= '0;
         bus.EN_LTSSM        <= 1'b0;
         bus.Soft_RST_blocks <= 1'b0;
         bus.deskew_locked   <= 1'b0;
         bus.deskew_fail     <= 1'b0;
         bus.rx_data_gate    <= 1'b0;
      end else begin
         state     <= next;
         flush_cnt <= (state == FLUSH && next == FLUSH) ?
                      flush_cnt + 4'd1 : 4'd0;
         timer     <= (state == ARM && next == ARM) ?
                      timer + TW'(1) : '0;
         if (state == IDLE && next == FLUSH)
            retry <= '0;
         else if (next == BACKOFF && state != BACKOFF &&
                  retry != RW'(MAX_RETRY))
            retry <= retry + RW'(1);
         bus.EN_LTSSM        <= (next == ARM) || (next == LOCKED);
         bus.Soft_RST_blocks <= (next == FLUSH);
         bus.deskew_locked   <= (next == LOCKED);
         bus.deskew_fail     <= (next == FAIL);
         bus.rx_data_gate    <= (next == LOCKED);
      end
   end

   assign bus.retry_cnt = retry;
endmodule

// File: tb/tb_deskew_sequencer.sv
// Directed bench for deskew_sequencer with a cycle-tagged scoreboard
// checked by an independent monitor.
module tb_deskew_sequencer;
   localparam int LANES = 32;
   localparam int RW    = 2;

   typedef struct {
      int          at;
      string       name;
      logic        en;
      logic        sr;
      logic        lk;
      logic        fl;
      logic [RW-1:0] rc;
   } exp_t;

   logic RX_CLK = 1'b0;
   logic rst    = 1'b1;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   deskew_sequencer_if #(.lane_count(LANES), .MAX_RETRY(3)) bus ();

   deskew_sequencer #(
      .lane_count(LANES), .FLUSH_CYCLES(4),
      .SDS_TIMEOUT(16), .MAX_RETRY(3)
   ) dut (
      .RX_CLK(RX_CLK),
      .rst(rst),
      .bus(bus)
   );

   always #5 RX_CLK = ~RX_CLK;

   always @(posedge RX_CLK) cyc <= cyc + 1;

   always @(negedge RX_CLK) begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_chk = n_chk + 1;
         if (bus.EN_LTSSM !== e.en || bus.Soft_RST_blocks !== e.sr ||
             bus.deskew_locked !== e.lk || bus.rx_data_gate !== e.lk ||
             bus.deskew_fail !== e.fl || bus.retry_cnt !== e.rc ||
             e.at != cyc) begin
            n_fail = n_fail + 1;
            $display("FAIL %s cyc=%0d got en=%b sr=%b lk=%b gate=%b fl=%b rc=%0d want en=%b sr=%b lk=%b fl=%b rc=%0d",
                     e.name, cyc, bus.EN_LTSSM, bus.Soft_RST_blocks,
                     bus.deskew_locked, bus.rx_data_gate, bus.deskew_fail,
                     bus.retry_cnt, e.en, e.sr, e.lk, e.fl, e.rc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge RX_CLK);
      #1;
   endtask

   task automatic expect_o(input string name, input logic en,
                           input logic sr, input logic lk,
                           input logic fl, input int rc);
      exp_t e;
      e.at = cyc; e.name = name;
      e.en = en; e.sr = sr; e.lk = lk; e.fl = fl; e.rc = RW'(rc);
      sb.push_back(e);
   endtask

   // Enters FLUSH on the next edge then checks every flush cycle and ARM entry.
   task automatic flush_to_arm(input string name, input int rc);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         expect_o({name, "_flush"}, 0, 1, 0, 0, rc);
      end
      tick(1);
      expect_o({name, "_arm"}, 1, 0, 0, 0, rc);
   endtask

   initial begin
      bus.deskew_req   = 0;
      bus.Deskew_error = 0;
      bus.valid_deskew = 0;
      bus.valid_data   = '1;
      tick(2);
      expect_o("reset", 0, 0, 0, 0, 0);
      rst = 0;
      tick(1);
      expect_o("idle", 0, 0, 0, 0, 0);

      // basic lock; valid_deskew already high during the settle cycle
      bus.deskew_req = 1;
      flush_to_arm("basic", 0);
      bus.valid_deskew = 1;
      tick(1);
      expect_o("settle_ignore", 1, 0, 0, 0, 0);
      tick(1);
      expect_o("basic_lock", 1, 0, 1, 0, 0);
      tick(3);
      expect_o("lock_hold", 1, 0, 1, 0, 0);

      // lost lock
      bus.Deskew_error = 1;
      tick(1);
      expect_o("lost_backoff", 0, 0, 0, 0, 1);
      bus.Deskew_error = 0;
      bus.valid_deskew = 0;
      flush_to_arm("relock", 1);
      bus.valid_deskew = 1;
      tick(2);
      expect_o("relock", 1, 0, 1, 0, 1);

      bus.deskew_req = 0;
      bus.valid_deskew = 0;
      tick(1);
      expect_o("abort_locked", 0, 0, 0, 0, 1);

      // retry then lock
      bus.deskew_req = 1;
      flush_to_arm("retry1", 0);
      tick(1);
      bus.Deskew_error = 1;
      tick(1);
      expect_o("retry1_backoff", 0, 0, 0, 0, 1);
      bus.Deskew_error = 0;
      flush_to_arm("retry2", 1);
      tick(1);
      bus.Deskew_error = 1;
      tick(1);
      expect_o("retry2_backoff", 0, 0, 0, 0, 2);
      bus.Deskew_error = 0;
      flush_to_arm("retry3", 2);
      bus.valid_deskew = 1;
      tick(2);
      expect_o("retry_lock", 1, 0, 1, 0, 2);

      // reset while locked
      rst = 1;
      tick(1);
      expect_o("rst_locked", 0, 0, 0, 0, 0);
      bus.deskew_req = 0;
      bus.valid_deskew = 0;
      rst = 0;
      tick(1);
      expect_o("post_rst_idle", 0, 0, 0, 0, 0);

      // three timeouts -> sticky FAIL
      bus.deskew_req = 1;
      tick(1);
      expect_o("to_flush", 0, 1, 0, 0, 0);
      tick(19);
      expect_o("to_arm_last", 1, 0, 0, 0, 0);
      tick(1);
      expect_o("to_backoff1", 0, 0, 0, 0, 1);
      tick(42);
      expect_o("to_backoff3", 0, 0, 0, 0, 3);
      tick(1);
      expect_o("to_fail", 0, 0, 0, 1, 3);
      tick(5);
      expect_o("fail_sticky", 0, 0, 0, 1, 3);
      bus.deskew_req = 0;
      tick(1);
      expect_o("fail_clear", 0, 0, 0, 0, 3);

      // simultaneous error and valid: error wins
      bus.deskew_req = 1;
      flush_to_arm("simul", 0);
      tick(2);
      bus.Deskew_error = 1;
      bus.valid_deskew = 1;
      tick(1);
      expect_o("simul_backoff", 0, 0, 0, 0, 1);
      bus.Deskew_error = 0;
      bus.valid_deskew = 0;

      // valid only at timer=0 is ignored; attempt times out
      flush_to_arm("settle", 1);
      bus.valid_deskew = 1;
      tick(1);
      bus.valid_deskew = 0;
      expect_o("settle_t0", 1, 0, 0, 0, 1);
      tick(14);
      expect_o("settle_t15", 1, 0, 0, 0, 1);
      tick(1);
      expect_o("settle_timeout", 0, 0, 0, 0, 2);

      // partial lanes do not lock; abort mid-ARM
      flush_to_arm("partial", 2);
      tick(1);
      bus.valid_deskew = 1;
      bus.valid_data   = {1'b0, {(LANES - 1){1'b1}}};
      tick(1);
      expect_o("partial_lanes", 1, 0, 0, 0, 2);
      bus.deskew_req = 0;
      tick(1);
      expect_o("abort_arm", 0, 0, 0, 0, 2);

      tick(2);
      if (sb.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d want finish", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
